// File: rtl/hexfmt_pkg.sv
// hexfmt_pkg: shared types and helpers for the hexfmt_serializer slice.
//   state_e          - formatter FSM states (TERM is only reachable when
//                      HEXFMT_NEWLINE_EN is defined)
//   CHAR_*           - ASCII constants used by the encoder and terminator
//   nibble_to_ascii  - maps a 4-bit value to its ASCII hex digit
package hexfmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TERM = 2'd2
  } state_e;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_LA = 8'h61;
  localparam logic [7:0] CHAR_UA = 8'h41;
  localparam logic [7:0] CHAR_NL = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                  input logic       upper);
    logic [7:0] result;
    if (nibble < 4'd10) begin
      result = CHAR_0 + {4'h0, nibble};
    end else begin
      result = (upper ? CHAR_UA : CHAR_LA) + {4'h0, nibble} - 8'd10;
    end
    return result;
  endfunction

endpackage

// File: rtl/hexfmt_digit.sv
// hexfmt_digit: combinational nibble -> ASCII hex digit encoder.
//   Parameters: UPPER - nonzero selects 'A'-'F', zero selects 'a'-'f'.
//   Ports:      nibble (in, 4)  value to encode
//               ascii  (out, 8) ASCII character
module hexfmt_digit
  import hexfmt_pkg::*;
#(
  parameter int UPPER = 0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = nibble_to_ascii(nibble, UPPER != 0);
  end

endmodule

// File: rtl/hexfmt_serializer.sv
// hexfmt_serializer: streams a WIDTH-bit word as ASCII hex, one byte per
// cycle, most-significant nibble first, with a per-nibble zero mask.
//   Parameters: WIDTH (multiple of 4, >= 4), UPPER (1 = 'A'-'F').
//   Config macro: HEXFMT_NEWLINE_EN - append 0x0A to each word; out_last
//                 then marks the 0x0A instead of the final digit.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid/in_ready     input handshake; in_data, in_zmask sampled at accept
//     out_valid/out_ready   output handshake; out_char byte, out_last end of word
//     word_count            words fully emitted (wraps modulo 2^32)
module hexfmt_serializer
  import hexfmt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int UPPER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [WIDTH/4-1:0] in_zmask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_char,
  output logic               out_last,
  output logic [31:0]        word_count
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("hexfmt_serializer: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      word_count_q, word_count_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_char_q, out_char_d;
  logic             out_last_q, out_last_d;

  logic             out_hs;
  logic             accept;
  logic             word_end;
  logic [WIDTH-1:0] zmask_full;
  logic [3:0]       nibble_sel;
  logic [7:0]       digit_ascii;

  assign out_hs   = out_valid_q && out_ready;
  // Combinational from out_ready so the next word is taken on the last-byte
  // handshake and words stream without a bubble.
  assign in_ready = (state_q == IDLE) || (out_hs && out_last_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    zmask_full = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      zmask_full[i*4 +: 4] = {4{in_zmask[i]}};
    end
  end

  // Next-state: word progression first, then a same-cycle accept overrides
  // the return to IDLE.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    word_count_d = word_count_q;
    word_end     = 1'b0;

    case (state_q)
      EMIT: begin
        if (out_hs) begin
          if (idx_q == '0) begin
`ifdef HEXFMT_NEWLINE_EN
            state_d = TERM;
`else
            word_end = 1'b1;
`endif
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
`ifdef HEXFMT_NEWLINE_EN
      TERM: begin
        if (out_hs) begin
          word_end = 1'b1;
        end
      end
`endif
      default: begin
      end
    endcase

    if (word_end) begin
      word_count_d = word_count_q + 32'd1;
      state_d      = IDLE;
    end

    if (accept) begin
      data_d  = in_data & ~zmask_full;
      idx_d   = IDX_LAST;
      state_d = EMIT;
    end
  end

  // Outputs are registered: the character for the next cycle is encoded
  // from the next data/index, so a stall simply re-encodes held state.
  assign nibble_sel = data_d[{idx_d, 2'b00} +: 4];

  hexfmt_digit #(
    .UPPER(UPPER)
  ) u_digit (
    .nibble(nibble_sel),
    .ascii (digit_ascii)
  );

  always_comb begin
    out_valid_d = (state_d != IDLE);
    out_char_d  = '0;
    out_last_d  = 1'b0;
    case (state_d)
      EMIT: begin
        out_char_d = digit_ascii;
`ifdef HEXFMT_NEWLINE_EN
        out_last_d = 1'b0;
`else
        out_last_d = (idx_d == '0);
`endif
      end
      TERM: begin
        out_char_d = CHAR_NL;
        out_last_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      word_count_q <= '0;
      out_valid_q  <= 1'b0;
      out_char_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      word_count_q <= word_count_d;
      out_valid_q  <= out_valid_d;
      out_char_q   <= out_char_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_char   = out_char_q;
  assign out_last   = out_last_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_hexfmt_serializer.sv
// tb_hexfmt_serializer: drives two hexfmt_serializer instances (lower and
// upper case) with directed and random traffic and compares every output
// cycle against a queue of expected bytes built from the formatting rules.
module tb_hexfmt_serializer;

  localparam int W   = 16;
  localparam int NIB = W / 4;
`ifdef HEXFMT_NEWLINE_EN
  localparam bit NL = 1'b1;
`else
  localparam bit NL = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic [NIB-1:0] in_zmask;
  logic           out_ready;

  logic           in_ready_lo, out_valid_lo, out_last_lo;
  logic [7:0]     out_char_lo;
  logic [31:0]    word_count_lo;
  logic           in_ready_up, out_valid_up, out_last_up;
  logic [7:0]     out_char_up;
  logic [31:0]    word_count_up;

  hexfmt_serializer #(.WIDTH(W), .UPPER(0)) u_dut_lo (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_lo),
    .in_data(in_data), .in_zmask(in_zmask),
    .out_valid(out_valid_lo), .out_ready(out_ready),
    .out_char(out_char_lo), .out_last(out_last_lo),
    .word_count(word_count_lo)
  );

  hexfmt_serializer #(.WIDTH(W), .UPPER(1)) u_dut_up (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_up),
    .in_data(in_data), .in_zmask(in_zmask),
    .out_valid(out_valid_up), .out_ready(out_ready),
    .out_char(out_char_up), .out_last(out_last_up),
    .word_count(word_count_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] up;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_count;
  int          n_total;
  int          n_bad;
  bit          armed;
  bit          accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected byte sequence for one word, straight from the formatting rules.
  task automatic push_word(input logic [W-1:0] d, input logic [NIB-1:0] z);
    exp_t e;
    int   n;
    for (int i = NIB - 1; i >= 0; i--) begin
      n = int'((d >> (4 * i)) & 16'hF);
      if (z[i]) n = 0;
      e.lo   = (n < 10) ? 8'(48 + n) : 8'(97 + n - 10);
      e.up   = (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
      e.last = (i == 0) && !NL;
      exp_q.push_back(e);
    end
    if (NL) begin
      e.lo   = 8'h0A;
      e.up   = 8'h0A;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] d,
                      input logic [NIB-1:0] z, input logic ordy);
    logic exp_rdy;
    logic exp_vld;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    in_zmask  = z;
    out_ready = ordy;
    @(negedge clk);
    exp_vld = (exp_q.size() != 0);
    exp_rdy = !exp_vld || (ordy && exp_q[0].last);
    if (armed) begin
      chk("out_valid_lo", {31'b0, out_valid_lo}, {31'b0, exp_vld});
      chk("out_valid_up", {31'b0, out_valid_up}, {31'b0, exp_vld});
      chk("in_ready_lo", {31'b0, in_ready_lo}, {31'b0, exp_rdy});
      chk("in_ready_up", {31'b0, in_ready_up}, {31'b0, exp_rdy});
      chk("word_count_lo", word_count_lo, exp_count);
      chk("word_count_up", word_count_up, exp_count);
      if (exp_vld) begin
        chk("out_char_lo", {24'b0, out_char_lo}, {24'b0, exp_q[0].lo});
        chk("out_char_up", {24'b0, out_char_up}, {24'b0, exp_q[0].up});
        chk("out_last_lo", {31'b0, out_last_lo}, {31'b0, exp_q[0].last});
        chk("out_last_up", {31'b0, out_last_up}, {31'b0, exp_q[0].last});
      end
    end
    accepted = 1'b0;
    if (r) begin
      exp_q.delete();
      exp_count = '0;
    end else begin
      if (exp_vld && ordy) begin
        if (exp_q[0].last) exp_count = exp_count + 32'd1;
        void'(exp_q.pop_front());
      end
      if (iv && exp_rdy) begin
        push_word(d, z);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [NIB-1:0] z);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      step(1'b0, 1'b1, d, z, 1'b1);
      done = accepted;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'b1);
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    armed     = 1'b0;
    exp_count = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_zmask  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    armed = 1'b1;
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

    chk("rst_out_valid", {31'b0, out_valid_lo}, 32'd0);
    chk("rst_out_last",  {31'b0, out_last_lo},  32'd0);
    chk("rst_out_char",  {24'b0, out_char_lo},  32'h00);
    chk("rst_word_count", word_count_lo, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready_lo},  32'd1);

    send(16'habcd, 4'b0000); drain();
    chk("wc_abcd", word_count_lo, 32'd1);
    send(16'habcd, 4'b0010); drain();
    send(16'habcd, 4'b1111); drain();
    send(16'h00fe, 4'b0000); drain();
    chk("wc_00fe", word_count_up, 32'd4);

    send(16'h1234, 4'b0000);
    send(16'h5678, 4'b0000);
    drain();
    chk("wc_b2b", word_count_lo, 32'd6);

    send(16'hbeef, 4'b0000);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    drain();
    chk("wc_beef", word_count_lo, 32'd7);

    send(16'habcd, 4'b0000);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 16'h1111, 4'h0, 1'b1);
    chk("midrst_out_valid", {31'b0, out_valid_lo}, 32'd0);
    chk("midrst_word_count", word_count_lo, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready_lo}, 32'd1);
    send(16'h0001, 4'b0000); drain();
    chk("wc_0001", word_count_lo, 32'd1);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(63) == 0), 1'($urandom_range(1)), 16'($urandom),
           ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom),
           ($urandom_range(9) < 7));
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hexfmt_serializer.md
# hexfmt_serializer

Streaming hex formatter that turns a WIDTH-bit data word into ASCII hex characters, one byte per cycle, most-significant nibble first. A per-nibble zero mask lets the producer blank selected fields, so `ab0d` comes from `abcd` with nibble 1 masked. It sits between debug/trace producers and a byte-wide console or UART sink in simulation-facing test infrastructure. It generalises fixed-width formatted display into a parametrised, flow-controlled block.

## Interface
Parameters:
- WIDTH, 16: data width in bits; must be a multiple of 4 and ≥4. Elaboration error otherwise.
- UPPER, 0: 1 emits `A`–`F`; 0 emits `a`–`f`.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous and active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to format.
- in_zmask  input  WIDTH/4  bit i set forces nibble i (bits 4i+3:4i) to 0.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  sink accepts out_char.
- out_char  output  8  ASCII byte.
- out_last  output  1  marks the final byte of the current word.
- word_count  output  32  number of words fully emitted. Wraps modulo 2^32.

## Operation
- States:
  - IDLE: no word held.
  - EMIT: emitting a digit.
  - TERM: emitting the terminator. This state exists only with HEXFMT_NEWLINE_EN.
- Accept: an input handshake occurs when in_valid && in_ready.
  - On accept, latch `in_data & ~expand(in_zmask)`. Each mask bit covers its 4 data bits.
  - Set the digit index to WIDTH/4-1 and enter EMIT.
- EMIT:
  - out_valid=1.
  - out_char is the ASCII of the nibble at the current index: 0x30–0x39 for 0–9, and 0x61–0x66 (UPPER=0) or 0x41–0x46 (UPPER=1) for 10–15.
  - On an output handshake, decrement the index.
  - At index 0 the handshake goes to TERM when the macro is defined, otherwise ends the word.
- TERM: out_char=0x0A and out_valid=1. The handshake ends the word.
- out_last=1 on the final byte of the word. That byte is the index-0 digit without the macro, or the 0x0A with it.
- Word end:
  - word_count increments on the handshake of the out_last byte.
  - The block returns to IDLE, or accepts the next word in the same cycle (see in_ready).
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - This path is combinational from out_ready, so back-to-back words stream with no bubble.
- Backpressure: while out_valid && !out_ready, out_char, out_last and internal state hold unchanged.
- in_data and in_zmask are sampled only at accept. Later changes have no effect on the word in flight.

## Timing
- Reset values: state IDLE, out_valid=0, out_last=0, out_char=0x00, word_count=0. in_ready=1 from the first cycle after reset.
- Latency: a word accepted at edge N has its first char valid in cycle N+1.
- Throughput: one byte per cycle with out_ready held high. A word occupies WIDTH/4 cycles, or WIDTH/4+1 with the terminator.
- Reset mid-word:
  - The word is abandoned and out_valid=0 the cycle after the reset edge.
  - No out_last is emitted and word_count is cleared.
  - rst has priority over any simultaneous handshake.
- Simultaneous last-byte handshake and new accept:
  - word_count increments.
  - The new word's first digit is valid the next cycle.
- word_count wraps from 0xFFFFFFFF to 0.

## Configuration
- HEXFMT_NEWLINE_EN:
  - Defined: every word is terminated by 0x0A in state TERM, and out_last is on the 0x0A.
  - Undefined: TERM is not compiled and out_last is on the last digit.

## Structure
- Package hexfmt_pkg:
  - state enum (IDLE/EMIT/TERM).
  - ASCII constants: CHAR_0, CHAR_LA, CHAR_UA, CHAR_NL.
  - function `nibble_to_ascii(nibble, upper)`.
- One sub-module, hexfmt_digit: combinational nibble→ASCII encoder, instantiated once on the selected nibble.
- The top holds the FSM, data register, index counter and word_count.

## Test plan
- WIDTH=16, UPPER=0, macro off, data 16'habcd, zmask 4'b0000, out_ready=1 → `a`,`b`,`c`,`d` (0x61,0x62,0x63,0x64) on consecutive cycles. out_last on `d`; word_count=1.
- Same data, zmask 4'b0010 → `a`,`b`,`0`,`d`. zmask 4'b1111 → `0000`.
- UPPER=1, macro on, data 16'h00fe → `0`,`0`,`F`,`E`,0x0A. out_last on 0x0A only.
- Two words (16'h1234, 16'h5678) offered back-to-back with out_ready=1 → 8 contiguous bytes with no gap; in_ready pulses high on the `4` handshake; word_count=2.
- out_ready toggled 1,0,0,1 during word 16'hbeef → out_char holds `e` across both stall cycles and the output is `beef`, no duplicate or lost byte.
- rst asserted while the third digit of 16'habcd is valid → out_valid=0 next cycle, word_count=0, in_ready=1. A following word 16'h0001 emits `0001` cleanly.
